mem_access_unit: RTL and testbench

- Parametrised multi-cycle memory access unit for the MIPS CPU core.
- Translates one load/store instruction (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW) into a single Avalon-style data-bus transaction.
- Honours waitrequest, generates lane byteenables and write-data replication, and sign/zero-extends or merges the read data into a 32-bit register result.
- Sits between the execute stage and the data memory bus; the core stalls while busy=1.

---
 rtl/mips_pkg.sv | 61 ++++++
 rtl/mem_access_unit_if.sv | 42 ++++
 rtl/mem_lane_align.sv | 84 ++++++++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: memory instruction codes, access-unit FSM
// states and small decode helpers used by the load/store path.
package mips_pkg;

  typedef enum logic [6:0] {
    LB  = 7'd42,
    LBU = 7'd43,
    LH  = 7'd44,
    LHU = 7'd45,
    LUI = 7'd46,
    LW  = 7'd47,
    LWL = 7'd48,
    LWR = 7'd49,
    SB  = 7'd50,
    SH  = 7'd51,
    SW  = 7'd52
  } instcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_DONE
  } state_e;

  // True for every opcode that needs a data-bus cycle (LUI does not).
  function automatic logic is_mem_op(input logic [6:0] op);
    case (op)
      LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [6:0] op);
    case (op)
      LB, LBU, LH, LHU, LW, LWL, LWR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Halfword accesses need an even offset, word accesses offset 0.
  // LWL/LWR are unaligned by design and never fault.
  function automatic logic misaligned(input logic [6:0] op, input logic [1:0] off);
    case (op)
      LH, LHU, SH: return off[0];
      LW, SW:      return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Offset used when alignment faults are disabled: drop the low bits
  // that would make the access straddle its natural boundary.
  function automatic logic [1:0] mask_off(input logic [6:0] op, input logic [1:0] off);
    case (op)
      LH, LHU, SH: return {off[1], 1'b0};
      LW, SW:      return 2'b00;
      default:     return off;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request and data-bus bundle of the memory access unit. The "master"
// modport is the access unit itself (it is the Avalon bus master); the
// "slave" modport is its environment: execute stage plus data memory.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();

  // request side (from execute stage)
  logic                  start;
  logic [6:0]            instcode;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           store_data;
  logic [31:0]           rt_old;
  // completion side (to core)
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [31:0]           result;
  // Avalon data bus
  logic [ADDR_WIDTH-1:0] bus_address;
  logic                  bus_read;
  logic                  bus_write;
  logic [3:0]            bus_byteenable;
  logic [31:0]           bus_writedata;
  logic                  bus_waitrequest;
  logic [31:0]           bus_readdata;

  modport master (
    input  start, instcode, address, store_data, rt_old,
    output busy, done, err, result,
    output bus_address, bus_read, bus_write, bus_byteenable, bus_writedata,
    input  bus_waitrequest, bus_readdata
  );

  modport slave (
    output start, instcode, address, store_data, rt_old,
    input  busy, done, err, result,
    input  bus_address, bus_read, bus_write, bus_byteenable, bus_writedata,
    output bus_waitrequest, bus_readdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-result extension / LWL-LWR merge for a little-endian 32-bit bus.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [6:0]  instcode,
  input  logic [1:0]  off,
  input  logic [31:0] readdata,
  input  logic [31:0] store_data,
  input  logic [31:0] rt_old,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_result
);

  logic [3:0]  upto_off;   // lanes 0..off  (LWL)
  logic [3:0]  from_off;   // lanes off..3  (LWR)
  logic [4:0]  sh_off;     // 8*off
  logic [4:0]  sh_left;    // 8*(3-off)
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign upto_off[gi] = (2'(gi) <= off);
    assign from_off[gi] = (2'(gi) >= off);
  end

  assign sh_off   = {off, 3'b000};
  assign sh_left  = {2'd3 - off, 3'b000};
  assign byte_sel = 8'(readdata >> sh_off);
  assign half_sel = off[1] ? readdata[31:16] : readdata[15:0];

  // Decode lane enables, replicated write data and the register result.
  always_comb begin
    byteenable  = 4'b0000;
    writedata   = store_data;
    load_result = 32'h0000_0000;
    case (instcode)
      LB: begin
        byteenable  = 4'b0001 << off;
        load_result = {{24{byte_sel[7]}}, byte_sel};
      end
      LBU: begin
        byteenable  = 4'b0001 << off;
        load_result = {24'h00_0000, byte_sel};
      end
      LH: begin
        byteenable  = off[1] ? 4'b1100 : 4'b0011;
        load_result = {{16{half_sel[15]}}, half_sel};
      end
      LHU: begin
        byteenable  = off[1] ? 4'b1100 : 4'b0011;
        load_result = {16'h0000, half_sel};
      end
      LW: begin
        byteenable  = 4'b1111;
        load_result = readdata;
      end
      LWL: begin
        byteenable  = upto_off;
        // memory fills the top bytes, rt keeps its low (3-off) bytes
        load_result = (readdata << sh_left) | (rt_old & (32'h00FF_FFFF >> sh_off));
      end
      LWR: begin
        byteenable  = from_off;
        // memory fills the bottom bytes, rt keeps its high off bytes
        load_result = (readdata >> sh_off) | (rt_old & ~(32'hFFFF_FFFF >> sh_off));
      end
      SB: begin
        byteenable = 4'b0001 << off;
        writedata  = {4{store_data[7:0]}};
      end
      SH: begin
        byteenable = off[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{store_data[15:0]}};
      end
      SW: begin
        byteenable = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: turns one MIPS memory instruction into a
// single Avalon read or write, then reports done/err/result to the core.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int ALIGN_CHECK = 1,
  parameter int TIMEOUT     = 0
) (
  input  logic clk,
  input  logic reset,
  mem_access_unit_if.master io
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                state_q;
  logic [6:0]            inst_q;
  logic [1:0]            off_q;
  logic [31:0]           rt_old_q;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [CNT_W-1:0]      wait_cnt_d;
  logic [31:0]           pend_result_q;   // result published at done
  logic                  pend_err_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [31:0]           result_q;
  logic [ADDR_WIDTH-1:0] bus_address_q;
  logic                  bus_read_q;
  logic                  bus_write_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;

  logic [1:0]  addr_off;
  logic [1:0]  eff_off;
  logic [6:0]  lane_inst;
  logic [1:0]  lane_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_result;
  logic        timeout_hit;

  assign addr_off    = io.address[1:0];
  assign eff_off     = (ALIGN_CHECK != 0) ? addr_off : mask_off(io.instcode, addr_off);
  assign wait_cnt_d  = wait_cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT > 0) && (int'(wait_cnt_d) == TIMEOUT);

  // In IDLE the lane logic sees the incoming request so enables and write
  // data can be registered at acceptance; afterwards it sees the latched
  // instruction so DATA can build the load result.
  assign lane_inst = (state_q == S_IDLE) ? io.instcode : inst_q;
  assign lane_off  = (state_q == S_IDLE) ? eff_off     : off_q;

  mem_lane_align u_lane (
    .instcode    (lane_inst),
    .off         (lane_off),
    .readdata    (io.bus_readdata),
    .store_data  (io.store_data),
    .rt_old      (rt_old_q),
    .byteenable  (lane_be),
    .writedata   (lane_wdata),
    .load_result (lane_result)
  );

  // Access FSM with all core and bus outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      inst_q        <= 7'd0;
      off_q         <= 2'b00;
      rt_old_q      <= 32'h0;
      wait_cnt_q    <= '0;
      pend_result_q <= 32'h0;
      pend_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      result_q      <= 32'h0;
      bus_address_q <= '0;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      be_q          <= 4'b0000;
      wdata_q       <= 32'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (done_q) begin
            // completion cycle: the core is still stalled, so no new request
            busy_q <= 1'b0;
            err_q  <= 1'b0;
          end else if (io.start) begin
            busy_q        <= 1'b1;
            inst_q        <= io.instcode;
            off_q         <= eff_off;
            rt_old_q      <= io.rt_old;
            wait_cnt_q    <= '0;
            pend_result_q <= 32'h0;
            pend_err_q    <= 1'b0;
            if (!is_mem_op(io.instcode)) begin
              state_q <= S_DONE;
            end else if ((ALIGN_CHECK != 0) && misaligned(io.instcode, addr_off)) begin
              pend_err_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              bus_address_q <= {io.address[ADDR_WIDTH-1:2], 2'b00};
              bus_read_q    <= is_load(io.instcode);
              bus_write_q   <= !is_load(io.instcode);
              be_q          <= lane_be;
              wdata_q       <= lane_wdata;
              state_q       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!io.bus_waitrequest) begin
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            be_q        <= 4'b0000;
            state_q     <= bus_read_q ? S_DATA : S_DONE;
          end else if (timeout_hit) begin
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            be_q        <= 4'b0000;
            pend_err_q  <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_DATA: begin
          pend_result_q <= lane_result;
          state_q       <= S_DONE;
        end
        S_DONE: begin
          done_q   <= 1'b1;
          err_q    <= pend_err_q;
          result_q <= pend_result_q;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.busy           = busy_q;
  assign io.done           = done_q;
  assign io.err            = err_q;
  assign io.result         = result_q;
  assign io.bus_address    = bus_address_q;
  assign io.bus_read       = bus_read_q;
  assign io.bus_write      = bus_write_q;
  assign io.bus_byteenable = be_q;
  assign io.bus_writedata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (ALIGN_CHECK=1, TIMEOUT=4).
module tb_mem_access_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_n    = 0;

  mem_access_unit_if #(.ADDR_WIDTH(32)) io ();

  mem_access_unit #(
    .ADDR_WIDTH  (32),
    .ALIGN_CHECK (1),
    .TIMEOUT     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; afterwards cyc_n counts cycles since start.
  task automatic issue(input logic [6:0] inst, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] rt);
    io.instcode   = inst;
    io.address    = addr;
    io.store_data = sd;
    io.rt_old     = rt;
    io.start      = 1'b1;
    cyc_n         = 0;
    tick();
    io.start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat,
                           input logic exp_err, input logic [31:0] exp_res);
    int k = 0;
    while (io.done !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check({tag, " done_seen"}, 32'(io.done), 32'd1);
    check({tag, " latency"}, cyc_n, exp_lat);
    check({tag, " err"}, 32'(io.err), 32'(exp_err));
    check({tag, " result"}, io.result, exp_res);
    $display("txn %s: latency=%0d err=%0b result=%h", tag, cyc_n, io.err, io.result);
    tick();
    check({tag, " done_pulse_len"}, 32'(io.done), 32'd0);
    check({tag, " busy_after"}, 32'(io.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    reset              = 1'b1;
    io.start           = 1'b0;
    io.instcode        = 7'd0;
    io.address         = 32'h0;
    io.store_data      = 32'h0;
    io.rt_old          = 32'h0;
    io.bus_waitrequest = 1'b0;
    io.bus_readdata    = 32'h0;
    repeat (3) tick();
    check("reset busy", 32'(io.busy), 32'd0);
    check("reset done", 32'(io.done), 32'd0);
    check("reset err", 32'(io.err), 32'd0);
    check("reset rw", {30'd0, io.bus_read, io.bus_write}, 32'd0);
    check("reset be", 32'(io.bus_byteenable), 32'd0);
    check("reset addr", io.bus_address, 32'd0);
    check("reset wdata", io.bus_writedata, 32'd0);
    check("reset result", io.result, 32'd0);
    reset = 1'b0;
    tick();

    // SW, no wait
    issue(SW, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0);
    check("SW write", 32'(io.bus_write), 32'd1);
    check("SW read", 32'(io.bus_read), 32'd0);
    check("SW be", 32'(io.bus_byteenable), 32'hF);
    check("SW wdata", io.bus_writedata, 32'hDEAD_BEEF);
    check("SW addr", io.bus_address, 32'h0000_1000);
    check("SW busy", 32'(io.busy), 32'd1);
    tick();
    check("SW write dropped", 32'(io.bus_write), 32'd0);
    wait_done("SW", 3, 1'b0, 32'h0);

    // LB with two wait cycles
    io.bus_waitrequest = 1'b1;
    io.bus_readdata    = 32'h8011_2233;
    issue(LB, 32'h0000_1003, 32'h0, 32'h0);
    check("LB read", 32'(io.bus_read), 32'd1);
    check("LB be", 32'(io.bus_byteenable), 32'b1000);
    check("LB addr", io.bus_address, 32'h0000_1000);
    tick();
    check("LB read held", 32'(io.bus_read), 32'd1);
    tick();
    io.bus_waitrequest = 1'b0;
    wait_done("LB", 6, 1'b0, 32'hFFFF_FF80);
    tick();
    check("LB result holds", io.result, 32'hFFFF_FF80);

    issue(LBU, 32'h0000_1003, 32'h0, 32'h0);
    wait_done("LBU", 4, 1'b0, 32'h0000_0080);

    // SH upper half
    issue(SH, 32'h0000_2002, 32'h0000_ABCD, 32'h0);
    check("SH be", 32'(io.bus_byteenable), 32'b1100);
    check("SH wdata", io.bus_writedata, 32'hABCD_ABCD);
    check("SH addr", io.bus_address, 32'h0000_2000);
    wait_done("SH", 3, 1'b0, 32'h0);

    // LH sign extension of upper half
    io.bus_readdata = 32'h8001_1234;
    issue(LH, 32'h0000_2002, 32'h0, 32'h0);
    wait_done("LH", 4, 1'b0, 32'hFFFF_8001);

    // LWL / LWR merges
    io.bus_readdata = 32'h1122_3344;
    issue(LWL, 32'h0000_3001, 32'h0, 32'hAABB_CCDD);
    check("LWL be", 32'(io.bus_byteenable), 32'b0011);
    wait_done("LWL", 4, 1'b0, 32'h3344_CCDD);
    issue(LWR, 32'h0000_3002, 32'h0, 32'hAABB_CCDD);
    check("LWR be", 32'(io.bus_byteenable), 32'b1100);
    wait_done("LWR", 4, 1'b0, 32'hAABB_1122);

    // misaligned LW: no bus cycle
    issue(LW, 32'h0000_1001, 32'h0, 32'h0);
    check("LW misaligned no read", 32'(io.bus_read), 32'd0);
    wait_done("LW misaligned", 2, 1'b1, 32'h0);

    // non-memory opcode
    issue(LUI, 32'h0000_1000, 32'h0, 32'h0);
    check("LUI no read", 32'(io.bus_read), 32'd0);
    wait_done("LUI", 2, 1'b0, 32'h0);

    // timeout with waitrequest stuck high
    io.bus_waitrequest = 1'b1;
    issue(LW, 32'h0000_1004, 32'h0, 32'h0);
    tick(); tick(); tick();
    check("TO read at 4", 32'(io.bus_read), 32'd1);
    tick();
    check("TO read dropped", 32'(io.bus_read), 32'd0);
    wait_done("LW timeout", 6, 1'b1, 32'h0);
    io.bus_waitrequest = 1'b0;

    // start while busy is ignored
    io.bus_readdata = 32'hCAFE_F00D;
    issue(LW, 32'h0000_1008, 32'h0, 32'h0);
    io.instcode = SB;
    io.address  = 32'h0000_4000;
    io.start    = 1'b1;
    tick();
    io.start = 1'b0;
    check("busy start no write", 32'(io.bus_write), 32'd0);
    wait_done("LW busy-start", 4, 1'b0, 32'hCAFE_F00D);
    check("busy start no new req", {30'd0, io.bus_read, io.bus_write}, 32'd0);

    // reset during REQ
    io.bus_waitrequest = 1'b1;
    issue(LW, 32'h0000_100C, 32'h0, 32'h0);
    check("RST read before", 32'(io.bus_read), 32'd1);
    reset = 1'b1;
    tick();
    check("RST read", 32'(io.bus_read), 32'd0);
    check("RST be", 32'(io.bus_byteenable), 32'd0);
    check("RST addr", io.bus_address, 32'd0);
    check("RST busy", 32'(io.busy), 32'd0);
    reset = 1'b0;
    io.bus_waitrequest = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (io.done === 1'b1) saw_done = 1'b1;
    end
    check("RST no done", 32'(saw_done), 32'd0);
    $display("txn RESET-in-REQ: aborted");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
